// File: rtl/ex_mc_alu.sv
// Registered execute stage: logic/shift/add/compare plus iterative multiply and divide into HI/LO.
// Latency: single-cycle ops 1 cycle; MULT/MULTU/DIV/DIVU DATA_W cycles from accept to valid_o.
// Backpressure: stall_o high while an iterative op runs; flush_i cancels it and frees the stage next cycle.
module ex_mc_alu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [4:0]        op_i,
    input  logic [DATA_W-1:0] rdata1_i,
    input  logic [DATA_W-1:0] rdata2_i,
    input  logic [ADDR_W-1:0] waddr_reg_i,
    input  logic              we_reg_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] waddr_reg_o,
    output logic              we_reg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [4:0] OP_OR    = 5'd0;
    localparam logic [4:0] OP_AND   = 5'd1;
    localparam logic [4:0] OP_NOR   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_SLL   = 5'd4;
    localparam logic [4:0] OP_SRL   = 5'd5;
    localparam logic [4:0] OP_SRA   = 5'd6;
    localparam logic [4:0] OP_ADD   = 5'd7;
    localparam logic [4:0] OP_SUB   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [DATA_W-1:0]    acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]    acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0]    mag_q, mag_d;
    logic [DATA_W-1:0]    hi_q, hi_d;
    logic [DATA_W-1:0]    lo_q, lo_d;
    logic                 valid_q, valid_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic                 is_mul_op, is_div_op, is_signed_op, op_known;
    logic                 a_neg, b_neg, last_iter;
    logic [DATA_W-1:0]    a_mag, b_mag;
    logic [SHAMT_W-1:0]   shamt;
    logic [DATA_W-1:0]    alu_res;
    logic [DATA_W:0]      mul_sum, div_sh, div_diff;
    logic [DATA_W-1:0]    it_hi, it_lo, fin_hi, fin_lo;
    logic [2*DATA_W-1:0]  prod;

    assign is_mul_op    = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div_op    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign is_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign op_known     = (op_i <= OP_MFLO);
    assign a_neg        = is_signed_op & rdata1_i[DATA_W-1];
    assign b_neg        = is_signed_op & rdata2_i[DATA_W-1];
    assign a_mag        = a_neg ? -rdata1_i : rdata1_i;
    assign b_mag        = b_neg ? -rdata2_i : rdata2_i;
    assign shamt        = rdata1_i[SHAMT_W-1:0];
    assign last_iter    = (cnt_q == SHAMT_W'(DATA_W - 1));

    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_OR:   alu_res = rdata1_i | rdata2_i;
            OP_AND:  alu_res = rdata1_i & rdata2_i;
            OP_NOR:  alu_res = ~(rdata1_i | rdata2_i);
            OP_XOR:  alu_res = rdata1_i ^ rdata2_i;
            OP_SLL:  alu_res = rdata2_i << shamt;
            OP_SRL:  alu_res = rdata2_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(rdata2_i) >>> shamt);
            OP_ADD:  alu_res = rdata1_i + rdata2_i;
            OP_SUB:  alu_res = rdata1_i - rdata2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rdata1_i) < $signed(rdata2_i))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (rdata1_i < rdata2_i)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // acc_hi:acc_lo is the partial product (multiplier shifts out of acc_lo) or
    // the partial remainder : dividend/quotient pair for restoring division.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? mag_q : {DATA_W{1'b0}})};
        div_sh   = {acc_hi_q, acc_lo_q[DATA_W-1]};
        div_diff = div_sh - {1'b0, mag_q};
        it_hi    = mul_sum[DATA_W:1];
        it_lo    = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        if (is_div_q) begin
            it_hi = div_diff[DATA_W] ? div_sh[DATA_W-1:0] : div_diff[DATA_W-1:0];
            it_lo = {acc_lo_q[DATA_W-2:0], ~div_diff[DATA_W]};
        end
        prod   = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
        fin_hi = prod[2*DATA_W-1:DATA_W];
        fin_lo = prod[DATA_W-1:0];
        if (is_div_q) begin
            fin_hi = rneg_q ? -it_hi : it_hi;
            fin_lo = dz_q ? {DATA_W{1'b1}} : (neg_q ? -it_lo : it_lo);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag_d    = mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        valid_d  = 1'b0;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_hi_d = it_hi;
                    acc_lo_d = it_lo;
                    cnt_d    = cnt_q + SHAMT_W'(1);
                    if (last_iter) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        hi_d    = fin_hi;
                        lo_d    = fin_lo;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                if (valid_i && !flush_i) begin
                    if (is_mul_op || is_div_op) begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        is_div_d = is_div_op;
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dz_d     = is_div_op && (rdata2_i == '0);
                        acc_hi_d = '0;
                        acc_lo_d = is_div_op ? a_mag : b_mag;
                        mag_d    = is_div_op ? b_mag : a_mag;
                    end else begin
                        valid_d = 1'b1;
                        we_d    = we_reg_i & op_known;
                        waddr_d = waddr_reg_i;
                        wdata_d = alu_res;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag_q    <= mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign stall_o     = (state_q == S_BUSY);
    assign valid_o     = valid_q;
    assign we_reg_o    = we_q;
    assign waddr_reg_o = waddr_q;
    assign wdata_o     = wdata_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule
